// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter and its neighbours: state encoding,
// default bus widths and a small port-select helper.
package sram_arbiter_pkg;

  localparam int ADDR_W_DEF      = 17;
  localparam int DATA_W_DEF      = 64;
  localparam int TIMEOUT_CYC_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One-hot completion vector {ack1, ack0} for a granted port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    logic [1:0] vec;
    if (idx) begin
      vec = 2'b10;
    end else begin
      vec = 2'b01;
    end
    return vec;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time
// is chosen; a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  // Winner selection from the request pair and the previous winner.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller port between two requesters with round-robin
// arbitration, a single outstanding transaction and a handshake watchdog.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              grant,
  output logic              busy,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                grant_q, grant_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                sram_req_q, sram_req_d;
  logic                sram_we_q, sram_we_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0]   sram_wdata_q, sram_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                arb_winner_s;
  logic                arb_valid_s;

  rr_arb2 u_rr_arb2 (
    .req    ({req1, req0}),
    .last   (last_q),
    .winner (arb_winner_s),
    .valid  (arb_valid_s)
  );

  // Next-state, latch and counter logic; every output is computed one cycle
  // ahead so the ports are driven straight from flops.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_d        = 1'b0;
    busy_d       = busy_q;
    sram_req_d   = sram_req_q;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          state_d    = ST_WAIT;
          grant_d    = arb_winner_s;
          last_d     = arb_winner_s;
          busy_d     = 1'b1;
          sram_req_d = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          if (arb_winner_s) begin
            sram_we_d    = we1;
            sram_addr_d  = addr1;
            sram_wdata_d = wdata1;
          end else begin
            sram_we_d    = we0;
            sram_addr_d  = addr0;
            sram_wdata_d = wdata0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // A ready arriving on the limit cycle takes priority over the abort.
        if (sram_ready) begin
          state_d          = ST_RESP;
          sram_req_d       = 1'b0;
          {ack1_d, ack0_d} = port_onehot(grant_q);
          if (!sram_we_q) begin
            rdata_d = sram_rdata;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          state_d          = ST_RESP;
          sram_req_d       = 1'b0;
          err_d            = 1'b1;
          rdata_d          = {DATA_W{1'b0}};
          {ack1_d, ack0_d} = port_onehot(grant_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = ST_IDLE;
        busy_d     = 1'b0;
        sram_req_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous reset; a reset mid-transaction drops
  // sram_req at once and suppresses the pending acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_q       <= 1'b1;
      grant_q      <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      sram_req_q   <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= {ADDR_W{1'b0}};
      sram_wdata_q <= {DATA_W{1'b0}};
      rdata_q      <= {DATA_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      sram_req_q   <= sram_req_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign sram_req   = sram_req_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a table of transactions with hand-computed
// results, plus short sequences for spurious ready and reset mid-WAIT.
module tb_sram_arbiter;

  localparam int ADDR_W      = 17;
  localparam int DATA_W      = 64;
  localparam int TIMEOUT_CYC = 31;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
  logic              ack0, ack1, err, grant, busy;
  logic [DATA_W-1:0] rdata;
  logic              sram_req, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              sram_ready = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata), .grant(grant), .busy(busy),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  always #5 clk = ~clk;

  // dly >= 0: sram_ready in the dly-th WAIT cycle (0 = first); dly < 0: never.
  // Port 1 presents addr ^ 17'h10000 and ~wdata so the latched winner is visible.
  typedef struct {
    bit          r0;
    bit          r1;
    bit          we;
    logic [16:0] addr;
    logic [63:0] wdata;
    int          dly;
    logic [63:0] srd;
    bit          exp_g;
    bit          exp_err;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input int idx, input vec_t v);
    logic [16:0] exp_addr;
    logic [63:0] exp_wd;
    int          waits;
    int          i;
    int          bad;
    bit          got;
    exp_addr = v.exp_g ? (v.addr ^ 17'h10000) : v.addr;
    exp_wd   = v.exp_g ? ~v.wdata : v.wdata;
    req0 = v.r0; req1 = v.r1;
    we0 = v.we; we1 = v.we;
    addr0 = v.addr; addr1 = v.addr ^ 17'h10000;
    wdata0 = v.wdata; wdata1 = ~v.wdata;
    waits = 0;
    got = 1'b0;
    while (!got && waits < 5) begin
      @(negedge clk);
      waits++;
      if (sram_req) got = 1'b1;
    end
    check($sformatf("txn%0d_req_latency", idx), 64'(waits), 64'd1);
    check($sformatf("txn%0d_grant", idx), 64'(grant), 64'(v.exp_g));
    check($sformatf("txn%0d_sram_addr", idx), 64'(sram_addr), 64'(exp_addr));
    check($sformatf("txn%0d_sram_we", idx), 64'(sram_we), 64'(v.we));
    check($sformatf("txn%0d_busy", idx), 64'(busy), 64'd1);
    // Toggle every requester field each WAIT cycle; latched values must hold.
    i = 0;
    bad = 0;
    got = 1'b0;
    while (!got && i < 60) begin
      sram_ready = (v.dly >= 0 && i == v.dly);
      sram_rdata = v.srd;
      we0 = ~we0; we1 = ~we1;
      addr0 = ~addr0; addr1 = ~addr1;
      wdata0 = ~wdata0; wdata1 = ~wdata1;
      @(negedge clk);
      i++;
      if (sram_addr !== exp_addr || sram_wdata !== exp_wd || sram_we !== v.we) bad++;
      if (ack0 || ack1) got = 1'b1;
    end
    sram_ready = 1'b0;
    check($sformatf("txn%0d_latched_stable", idx), 64'(bad), 64'd0);
    check($sformatf("txn%0d_ack_cycle", idx), 64'(i),
          (v.dly >= 0) ? 64'(v.dly + 1) : 64'(TIMEOUT_CYC + 1));
    check($sformatf("txn%0d_ack_vec", idx), 64'({ack1, ack0}), v.exp_g ? 64'd2 : 64'd1);
    check($sformatf("txn%0d_err", idx), 64'(err), 64'(v.exp_err));
    check($sformatf("txn%0d_rdata", idx), rdata, v.exp_rd);
    check($sformatf("txn%0d_sram_req_resp", idx), 64'(sram_req), 64'd0);
    if (v.exp_g) req1 = 1'b0;
    else req0 = 1'b0;
    @(negedge clk);
    check($sformatf("txn%0d_post", idx), 64'({ack1, ack0, err, busy}), 64'd0);
  endtask

  initial begin
    // Tie after reset: grants alternate 0,1,0,1.
    vecs[0]  = '{1, 1, 0, 17'h00010, 64'h0, 1, 64'hA0A0_0000_0000_0001, 0, 0, 64'hA0A0_0000_0000_0001};
    vecs[1]  = '{1, 1, 0, 17'h00020, 64'h0, 2, 64'hA0A0_0000_0000_0002, 1, 0, 64'hA0A0_0000_0000_0002};
    vecs[2]  = '{1, 1, 0, 17'h00030, 64'h0, 0, 64'hA0A0_0000_0000_0003, 0, 0, 64'hA0A0_0000_0000_0003};
    vecs[3]  = '{1, 1, 0, 17'h00040, 64'h0, 3, 64'hA0A0_0000_0000_0004, 1, 0, 64'hA0A0_0000_0000_0004};
    // Single read with ready four cycles into WAIT.
    vecs[4]  = '{1, 0, 0, 17'h000A5, 64'h0, 4, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'hDEAD_BEEF_0123_4567};
    // Write from port 1 (wdata1 = ~wdata): read data on the bus must not reach rdata.
    vecs[5]  = '{0, 1, 1, 17'h10123, ~64'h1111_2222_3333_4444, 2, 64'hFFFF_0000_FFFF_0000, 1, 0, 64'hDEAD_BEEF_0123_4567};
    // Timeout, then a normal read.
    vecs[6]  = '{1, 0, 0, 17'h00777, 64'h0, -1, 64'h0, 0, 1, 64'h0};
    vecs[7]  = '{0, 1, 0, 17'h00001, 64'h0, 0, 64'h5555_6666_7777_8888, 1, 0, 64'h5555_6666_7777_8888};
    // Ready on the limit cycle wins over the timeout.
    vecs[8]  = '{1, 0, 0, 17'h01F00, 64'h0, 31, 64'hCAFE_F00D_1234_5678, 0, 0, 64'hCAFE_F00D_1234_5678};
    vecs[9]  = '{1, 0, 1, 17'h00F0F, 64'h0123_0000_0000_3210, 1, 64'h9999_9999_9999_9999, 0, 0, 64'hCAFE_F00D_1234_5678};
    // After a mid-transaction reset the tie goes to port 0 again.
    vecs[10] = '{1, 1, 0, 17'h00BBB, 64'h0, 2, 64'h0BAD_CAFE_0000_0011, 0, 0, 64'h0BAD_CAFE_0000_0011};

    @(negedge clk);
    check("reset_outputs", 64'({ack0, ack1, err, busy, sram_req, sram_we, grant}), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    check("reset_sram_addr", 64'(sram_addr), 64'd0);
    check("reset_sram_wdata", sram_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) do_txn(k, vecs[k]);
    req0 = 1'b0; req1 = 1'b0;

    // Spurious ready while idle.
    sram_ready = 1'b1;
    sram_rdata = 64'h1234_1234_1234_1234;
    @(negedge clk);
    sram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("idle_ready_quiet%0d", k), 64'({ack0, ack1, err, busy, sram_req}), 64'd0);
      @(negedge clk);
    end
    check("idle_ready_rdata", rdata, 64'hCAFE_F00D_1234_5678);

    // Reset while WAIT is active.
    req0 = 1'b1; we0 = 1'b0; addr0 = 17'h00123;
    begin
      int w;
      w = 0;
      while (!sram_req && w < 5) begin
        @(negedge clk);
        w++;
      end
      check("rst_wait_reached", 64'(sram_req), 64'd1);
    end
    rst = 1'b1;
    #1;
    check("rst_async_sram_req", 64'({sram_req, busy}), 64'd0);
    req0 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("rst_no_ack%0d", k), 64'({ack0, ack1, err}), 64'd0);
    end
    rst = 1'b0;
    sram_ready = 1'b1;
    sram_rdata = 64'h7777_7777_7777_7777;
    @(negedge clk);
    sram_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_stale_ready%0d", k), 64'({ack0, ack1, err, busy, sram_req}), 64'd0);
      @(negedge clk);
    end
    check("rst_stale_rdata", rdata, 64'd0);

    do_txn(10, vecs[10]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
